lane_sprite_engine: RTL and testbench

- Parametrised successor to the racing-game car/lane logic.
- Owns player lane state for NUM_LANES lanes from raw left/right buttons, with synchronising and edge detection.
- Moves the car with a frame-locked slide animation and generates sprite ROM addresses.
- Composites sprite, road and grass into a pixel stream for VGA_LOGIC. Sits between the VGA timing counters, rom_Car and VGA_LOGIC in the pixel clock domain.

---
 rtl/lane_sprite_engine.sv | 190 +++++++++++++++++++
 tb/tb_lane_sprite_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lane_sprite_engine.sv
// Lane-based car sprite engine: button synchronisation, lane FSM with frame-locked
// slide animation, sprite ROM addressing and sprite/road/grass pixel compositing.
module lane_sprite_engine #(
    parameter int NUM_LANES  = 3,
    parameter int LANE0_X    = 197,
    parameter int LANE_PITCH = 82,
    parameter int SPRITE_W   = 80,
    parameter int SPRITE_H   = 121,
    parameter int SPRITE_Y   = 357,
    parameter int ROAD_X0    = 197,
    parameter int ROAD_X1    = 443,
    parameter int SLIDE_STEP = 4,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int COLOR_W    = 3,
    parameter int ADDR_W     = 14,
    parameter int SWAP_RGB   = 1,
    parameter int KEY_EN     = 1,
    parameter logic [COLOR_W-1:0] KEY_COLOR   = 3'b000,
    parameter logic [COLOR_W-1:0] ROAD_COLOR  = 3'b111,
    parameter logic [COLOR_W-1:0] GRASS_COLOR = 3'b010
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         left,
    input  logic                         right,
    input  logic [9:0]                   hcount,
    input  logic [9:0]                   vcount,
    input  logic [COLOR_W-1:0]           rom_data,
    output logic [ADDR_W-1:0]            sprite_addr,
    output logic [COLOR_W-1:0]           pixel_out,
    output logic [$clog2(NUM_LANES)-1:0] lane,
    output logic                         sliding
);
    localparam int LANE_W = $clog2(NUM_LANES);
    localparam logic [LANE_W-1:0] CENTER_LANE = LANE_W'(NUM_LANES / 2);
    localparam logic [9:0] CENTER_X = 10'(LANE0_X + (NUM_LANES / 2) * LANE_PITCH);

    typedef enum logic {IDLE, SLIDING} state_t;

    state_t state, state_next;
    logic [LANE_W-1:0] lane_next;
    logic [9:0] car_x, car_x_next, target_x, diff, step;
    logic pend_valid, pend_valid_next, pend_dir, pend_dir_next;
    logic [1:0] left_sync, right_sync, settle_cnt;
    logic left_prev, right_prev, left_pulse, right_pulse, settled;
    logic req_l, req_r, tick, apply_valid, apply_dir;
    logic in_spr, active, in_spr_q, active_q;
    logic [COLOR_W-1:0] bg, bg_q, spr_color;
    logic [ADDR_W-1:0] addr_calc;
    logic is_key;

    // Edge history is held high until the synchronisers have filled after reset,
    // so a button already held at reset release does not count as a press.
    assign settled = (settle_cnt == 2'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_sync   <= '0;
            right_sync  <= '0;
            settle_cnt  <= '0;
            left_prev   <= 1'b1;
            right_prev  <= 1'b1;
            left_pulse  <= 1'b0;
            right_pulse <= 1'b0;
        end else begin
            left_sync  <= {left_sync[0], left};
            right_sync <= {right_sync[0], right};
            if (!settled)
                settle_cnt <= settle_cnt + 2'd1;
            left_prev   <= settled ? left_sync[1] : 1'b1;
            right_prev  <= settled ? right_sync[1] : 1'b1;
            left_pulse  <= settled & left_sync[1] & ~left_prev;
            right_pulse <= settled & right_sync[1] & ~right_prev;
        end
    end

    assign req_l = left_pulse & ~right_pulse;
    assign req_r = right_pulse & ~left_pulse;
    assign tick  = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lane       <= CENTER_LANE;
            car_x      <= CENTER_X;
            pend_valid <= 1'b0;
            pend_dir   <= 1'b0;
        end else begin
            state      <= state_next;
            lane       <= lane_next;
            car_x      <= car_x_next;
            pend_valid <= pend_valid_next;
            pend_dir   <= pend_dir_next;
        end
    end

    always_comb begin
        state_next      = state;
        lane_next       = lane;
        car_x_next      = car_x;
        pend_valid_next = pend_valid;
        pend_dir_next   = pend_dir;
        apply_valid     = 1'b0;
        apply_dir       = 1'b0;
        target_x        = 10'(LANE0_X + int'(lane) * LANE_PITCH);
        diff            = (target_x > car_x) ? (target_x - car_x) : (car_x - target_x);
        step            = (diff > 10'(SLIDE_STEP)) ? 10'(SLIDE_STEP) : diff;
        case (state)
            IDLE: begin
                // A fresh button request takes precedence over a leftover pending one.
                if (req_l || req_r) begin
                    apply_valid = 1'b1;
                    apply_dir   = req_r;
                end else if (pend_valid) begin
                    apply_valid = 1'b1;
                    apply_dir   = pend_dir;
                end
                if (apply_valid) begin
                    pend_valid_next = 1'b0;
                    if (apply_dir && (lane != LANE_W'(NUM_LANES - 1))) begin
                        lane_next  = lane + LANE_W'(1);
                        state_next = SLIDING;
                    end else if (!apply_dir && (lane != '0)) begin
                        lane_next  = lane - LANE_W'(1);
                        state_next = SLIDING;
                    end
                end
            end
            SLIDING: begin
                if (req_l || req_r) begin
                    pend_valid_next = 1'b1;
                    pend_dir_next   = req_r;
                end
                if (tick) begin
                    car_x_next = (target_x > car_x) ? (car_x + step) : (car_x - step);
                    if (car_x_next == target_x)
                        state_next = IDLE;
                end
            end
        endcase
    end

    assign sliding = (state == SLIDING);

    assign in_spr = (hcount >= car_x) &&
                    ({1'b0, hcount} < ({1'b0, car_x} + 11'(SPRITE_W))) &&
                    (vcount >= 10'(SPRITE_Y)) &&
                    ({1'b0, vcount} < 11'(SPRITE_Y + SPRITE_H));
    assign addr_calc = ADDR_W'(vcount - 10'(SPRITE_Y)) * ADDR_W'(SPRITE_W) +
                       ADDR_W'(hcount - car_x);
    assign active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign bg = ((hcount >= 10'(ROAD_X0)) && (hcount < 10'(ROAD_X1))) ? ROAD_COLOR : GRASS_COLOR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sprite_addr <= '0;
            in_spr_q    <= 1'b0;
            active_q    <= 1'b0;
            bg_q        <= '0;
        end else begin
            if (in_spr)
                sprite_addr <= addr_calc;
            in_spr_q <= in_spr;
            active_q <= active;
            bg_q     <= bg;
        end
    end

    always_comb begin
        spr_color = rom_data;
        if (SWAP_RGB != 0) begin
            for (int i = 0; i < COLOR_W; i++)
                spr_color[i] = rom_data[COLOR_W-1-i];
        end
    end

    assign is_key = (KEY_EN != 0) && (spr_color == KEY_COLOR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pixel_out <= '0;
        else if (!active_q)
            pixel_out <= '0;
        else if (in_spr_q && !is_key)
            pixel_out <= spr_color;
        else
            pixel_out <= bg_q;
    end
endmodule

// File: tb/tb_lane_sprite_engine.sv
// Directed bench for lane_sprite_engine: lane moves, edge/cancel rules, pending
// requests, slide timing, pixel pipeline and asynchronous reset behaviour.
module tb_lane_sprite_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        left, right;
    logic [9:0]  hcount, vcount;
    logic [2:0]  rom_data;
    logic [13:0] sprite_addr;
    logic [2:0]  pixel_out;
    logic [1:0]  lane;
    logic        sliding;
    int          checks = 0;
    int          errors = 0;

    lane_sprite_engine dut (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hcount(hcount), .vcount(vcount), .rom_data(rom_data),
        .sprite_addr(sprite_addr), .pixel_out(pixel_out),
        .lane(lane), .sliding(sliding)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Press the given buttons long enough for one pulse, then release and let the synchronisers drain.
    task automatic applyStimulus(input logic l, input logic r);
        @(negedge clk);
        left  = l;
        right = r;
        repeat (5) @(negedge clk);
        left  = 1'b0;
        right = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frameTicks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hcount = 10'd0;
            vcount = 10'd480;
            @(negedge clk);
            hcount = 10'd700;
            vcount = 10'd500;
        end
    endtask

    task automatic setPixel(input logic [9:0] h, input logic [9:0] v, input logic [2:0] d);
        @(negedge clk);
        hcount   = h;
        vcount   = v;
        rom_data = d;
    endtask

    initial begin
        reset = 1'b0; left = 1'b0; right = 1'b0;
        hcount = 10'd700; vcount = 10'd500; rom_data = 3'b000;
        repeat (3) @(negedge clk);
        checkOutput("rst_lane", lane, 1);
        checkOutput("rst_car_x", dut.car_x, 279);
        checkOutput("rst_sliding", sliding, 0);
        checkOutput("rst_pixel", pixel_out, 0);
        checkOutput("rst_addr", sprite_addr, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("blank_pixel", pixel_out, 0);

        // Right from the centre lane: lane moves on the 4th clock
        right = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("lane_clk3", lane, 1);
        @(negedge clk);
        checkOutput("lane_clk4", lane, 2);
        checkOutput("sliding_start", sliding, 1);
        right = 1'b0;
        repeat (4) @(negedge clk);
        frameTicks(20);
        checkOutput("car_x_20", dut.car_x, 359);
        checkOutput("sliding_20", sliding, 1);
        frameTicks(1);
        checkOutput("car_x_21", dut.car_x, 361);
        checkOutput("sliding_21", sliding, 0);

        // Edge discard and cancellation
        applyStimulus(1'b0, 1'b1);
        checkOutput("edge_right_lane", lane, 2);
        checkOutput("edge_right_sliding", sliding, 0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("back_lane1", lane, 1);
        frameTicks(21);
        checkOutput("back_car_x", dut.car_x, 279);
        applyStimulus(1'b1, 1'b1);
        checkOutput("cancel_lane", lane, 1);
        checkOutput("cancel_sliding", sliding, 0);
        applyStimulus(1'b1, 1'b0);
        frameTicks(21);
        checkOutput("lane0", lane, 0);
        checkOutput("lane0_car_x", dut.car_x, 197);
        applyStimulus(1'b1, 1'b0);
        checkOutput("edge_left_lane", lane, 0);
        checkOutput("edge_left_sliding", sliding, 0);
        applyStimulus(1'b0, 1'b1);
        frameTicks(21);
        checkOutput("centre_car_x", dut.car_x, 279);

        // Pending reverse request during a slide
        applyStimulus(1'b0, 1'b1);
        frameTicks(5);
        checkOutput("mid_car_x", dut.car_x, 299);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pend_lane", lane, 2);
        checkOutput("pend_valid", dut.pend_valid, 1);
        frameTicks(16);
        checkOutput("arrive_car_x", dut.car_x, 361);
        checkOutput("arrive_sliding", sliding, 0);
        @(negedge clk);
        checkOutput("pend_apply_lane", lane, 1);
        checkOutput("pend_apply_sliding", sliding, 1);
        checkOutput("pend_cleared", dut.pend_valid, 0);
        frameTicks(21);
        checkOutput("return_car_x", dut.car_x, 279);
        checkOutput("return_sliding", sliding, 0);
        frameTicks(2);
        checkOutput("settled_lane", lane, 1);
        checkOutput("settled_car_x", dut.car_x, 279);

        // Pixel pipeline
        setPixel(10'd284, 10'd359, 3'b110);
        @(negedge clk);
        checkOutput("addr_165", sprite_addr, 165);
        rom_data = 3'b110;
        @(negedge clk);
        checkOutput("pix_swap_110", pixel_out, 3'b011);
        rom_data = 3'b000;
        @(negedge clk);
        checkOutput("pix_key", pixel_out, 3'b111);
        rom_data = 3'b001;
        @(negedge clk);
        checkOutput("pix_swap_001", pixel_out, 3'b100);
        setPixel(10'd100, 10'd100, 3'b101);
        @(negedge clk);
        checkOutput("addr_hold", sprite_addr, 165);
        @(negedge clk);
        checkOutput("pix_grass", pixel_out, 3'b010);
        setPixel(10'd300, 10'd100, 3'b101);
        repeat (2) @(negedge clk);
        checkOutput("pix_road", pixel_out, 3'b111);
        setPixel(10'd358, 10'd477, 3'b100);
        @(negedge clk);
        checkOutput("addr_corner", sprite_addr, 9679);
        @(negedge clk);
        checkOutput("pix_corner", pixel_out, 3'b001);
        setPixel(10'd359, 10'd477, 3'b100);
        @(negedge clk);
        checkOutput("addr_past_edge", sprite_addr, 9679);
        @(negedge clk);
        checkOutput("pix_past_edge", pixel_out, 3'b111);
        setPixel(10'd640, 10'd100, 3'b100);
        repeat (2) @(negedge clk);
        checkOutput("pix_inactive", pixel_out, 3'b000);
        setPixel(10'd700, 10'd500, 3'b000);

        // Asynchronous reset mid-slide with a held button
        applyStimulus(1'b0, 1'b1);
        frameTicks(5);
        applyStimulus(1'b1, 1'b0);
        checkOutput("pre_reset_pend", dut.pend_valid, 1);
        right = 1'b1;
        #2 reset = 1'b0;
        #1;
        checkOutput("async_lane", lane, 1);
        checkOutput("async_car_x", dut.car_x, 279);
        checkOutput("async_sliding", sliding, 0);
        checkOutput("async_pend", dut.pend_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("held_lane", lane, 1);
        checkOutput("held_sliding", sliding, 0);
        right = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("repress_lane", lane, 2);
        checkOutput("repress_sliding", sliding, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
